// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO register pair.
// One operand bit per cycle in RUN, sign fix-up and HI/LO write-back in FIX.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    // state    | meaning
    // ST_IDLE  | accepting MTHI/MTLO and new mul/div issues
    // ST_RUN   | one shift-add / shift-subtract step per cycle
    // ST_FIX   | apply result signs and write HI/LO
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic                 is_div_q, is_div_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh, trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // Negating the most-negative value wraps to itself, which is the correct
    // unsigned magnitude.
    always_comb begin
        mag_a = (op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b = (op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Restoring divide: remainder in the upper half, dividend bits shift out of
    // the lower half while quotient bits shift in.
    always_comb begin
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, opnd_q};
        if (!trial[WIDTH]) begin
            div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = (sa_q ^ sb_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = sa_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                            is_div_d = op[1];
                            sa_d     = op[0] & a[WIDTH-1];
                            sb_d     = op[0] & b[WIDTH-1];
                            opnd_d   = op[1] ? mag_b : mag_a;
                            acc_d    = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                            dz_d     = op[1] && (b == '0);
                            cnt_d    = '0;
                            state_d  = ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d     = 1'b1;
                    div_zero_d = dz_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign rd_data  = rd_sel ? hi_q : lo_q;

endmodule
